ascii_stream_arbiter: RTL

Round-robin arbiter that merges several ASCII character sources (UART receiver, keyboard decoder, on-chip message generator) into the single `ascii`/`ascii_val` write stream of the character buffer. It grants line-atomic ownership, so characters from different sources are never interleaved within one screen line. If a source stalls mid-line, the arbiter releases ownership after a timeout and injects a newline.

---
 rtl/ascii_stream_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ascii_stream_arbiter.sv
// Round-robin, line-atomic merge of several ASCII sources into one character stream.
// Latency: one cycle from an accepted character (or forced-release LF) to ascii/ascii_val.
// Backpressure: none downstream; requesters are held off via req_rdy while another source owns the line.
module ascii_stream_arbiter #(
    parameter int p_num_req = 2,
    parameter int p_timeout = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [8*p_num_req-1:0]       req_ascii,
    input  logic [p_num_req-1:0]         req_val,
    output logic [p_num_req-1:0]         req_rdy,
    output logic [7:0]                   ascii,
    output logic                         ascii_val,
    output logic                         locked,
    output logic [$clog2(p_num_req)-1:0] owner
);

    localparam int IW = $clog2(p_num_req);
    localparam int TW = $clog2(p_timeout + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   owner_q;
    logic [TW-1:0]   timer_q;
    logic [7:0]      ascii_q;
    logic            ascii_val_q;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [7:0]      win_char;
    logic [7:0]      own_char;
    logic            own_val;
    logic            timeout;
    int              scan_idx;

    // Increment with explicit wrap so non-power-of-two requester counts stay in range.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
        if (int'(x) == p_num_req - 1) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    // LF and ESC close a line; everything else (including DEL) is ordinary text.
    function automatic logic is_term(input logic [7:0] c);
        return (c == 8'h0A) || (c == 8'h1B);
    endfunction

    // Rotating priority search starting at ptr; scanned from the far end so the nearest requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = p_num_req - 1; i >= 0; i--) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= p_num_req) begin
                scan_idx = scan_idx - p_num_req;
            end
            if (req_val[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(scan_idx);
            end
        end
    end

    // Owner / winner views and the one-hot ready; ready is squashed during reset and the timeout cycle.
    always_comb begin
        win_char = req_ascii[int'(win_idx)*8 +: 8];
        own_char = req_ascii[int'(owner_q)*8 +: 8];
        own_val  = req_val[owner_q];
        timeout  = (state_q == ST_LOCKED) && (timer_q == TW'(p_timeout));
        req_rdy  = '0;
        if (rst_n) begin
            if (state_q == ST_IDLE) begin
                if (win_found) begin
                    req_rdy[win_idx] = 1'b1;
                end
            end else if (!timeout) begin
                req_rdy[owner_q] = own_val;
            end
        end
    end

    // Arbitration FSM with the registered output character and valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            timer_q     <= '0;
            ascii_q     <= 8'h00;
            ascii_val_q <= 1'b0;
        end else begin
            ascii_val_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        ascii_q     <= win_char;
                        ascii_val_q <= 1'b1;
                        if (is_term(win_char)) begin
                            // A lone terminator is a complete line; no lock is taken.
                            ptr_q <= next_idx(win_idx);
                        end else begin
                            state_q <= ST_LOCKED;
                            owner_q <= win_idx;
                            timer_q <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (timeout) begin
                        // Stalled owner: close its line on its behalf and hand over.
                        ascii_q     <= 8'h0A;
                        ascii_val_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        ptr_q       <= next_idx(owner_q);
                    end else if (own_val) begin
                        ascii_q     <= own_char;
                        ascii_val_q <= 1'b1;
                        if (is_term(own_char)) begin
                            state_q <= ST_IDLE;
                            ptr_q   <= next_idx(owner_q);
                        end else begin
                            timer_q <= '0;
                        end
                    end else if (timer_q != TW'(p_timeout)) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ascii     = ascii_q;
    assign ascii_val = ascii_val_q;
    assign locked    = (state_q == ST_LOCKED);
    assign owner     = owner_q;

endmodule
